// File: rtl/axis_packet_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : axis_packet_arbiter_if
//  Description : Bundle of the four AXI4-Stream source ports, the single
//                FIFO-side AXI4-Stream port and the sticky truncation flag
//                of the packet arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axis_packet_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic [4*DATA_WIDTH-1:0] s_axis_tdata;
    logic [3:0]              s_axis_tvalid;
    logic [3:0]              s_axis_tlast;
    logic [3:0]              s_axis_tready;
    logic [DATA_WIDTH-1:0]   m_axis_tdata;
    logic                    m_axis_tvalid;
    logic                    m_axis_tlast;
    logic [1:0]              m_axis_tid;
    logic                    m_axis_tready;
    logic                    trunc_err;

    // Arbiter side: consumes the sources, drives the FIFO
    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tid, trunc_err
    );

    // Environment side: the sources and the FIFO
    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tid, trunc_err
    );
endinterface
`default_nettype wire

// File: rtl/axis_packet_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : axis_packet_arbiter
//  Description : Packet-granular round-robin arbiter sharing one AXI4-Stream
//                FIFO port between four sources, with a beat-count watchdog
//                that forces tlast on runaway packets.
//  Revision    : 1.0 - initial release
// ============================================================================
module axis_packet_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int MAX_BEATS  = 256
) (
    input  wire logic            aclk,
    input  wire logic            aresetn,
    axis_packet_arbiter_if.slave bus
);

    localparam int c_CNT_W = (MAX_BEATS > 2) ? $clog2(MAX_BEATS) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(MAX_BEATS - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_grant;
    logic [1:0]         w_grant_nxt;
    logic [1:0]         r_rr_ptr;
    logic [1:0]         w_rr_ptr_nxt;
    logic [c_CNT_W-1:0] r_beat_cnt;
    logic [c_CNT_W-1:0] w_beat_cnt_nxt;
    logic               r_trunc_err;
    logic               w_trunc_err_nxt;

    logic [3:0]            w_rot_vld;
    logic [1:0]            w_rot_idx [4];
    logic                  w_win_found;
    logic [1:0]            w_win_idx;
    logic                  w_busy;
    logic                  w_wd_hit;
    logic                  w_m_tvalid;
    logic                  w_m_tlast;
    logic [DATA_WIDTH-1:0] w_m_tdata;
    logic [1:0]            w_m_tid;
    logic [3:0]            w_s_tready;
    logic                  w_xfer;

    // Candidate order for this arbitration round, starting at the pointer
    for (genvar k = 0; k < 4; k++) begin : g_rot
        assign w_rot_idx[k] = r_rr_ptr + 2'(k);
        assign w_rot_vld[k] = bus.s_axis_tvalid[w_rot_idx[k]];
    end

    // Pick the first valid source in round-robin order
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = r_rr_ptr;
        for (int k = 0; k < 4; k++) begin
            if (!w_win_found && w_rot_vld[k]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_rot_idx[k];
            end
        end
    end

    // Combinational pass-through from the granted source; all zero while idle
    always_comb begin
        w_busy     = (r_state == ST_BUSY);
        w_wd_hit   = (r_beat_cnt == c_LAST_BEAT);
        w_m_tvalid = w_busy & bus.s_axis_tvalid[r_grant];
        w_m_tlast  = w_busy & (bus.s_axis_tlast[r_grant] | w_wd_hit);
        w_m_tdata  = w_busy ? bus.s_axis_tdata[r_grant*DATA_WIDTH +: DATA_WIDTH]
                            : '0;
        w_m_tid    = w_busy ? r_grant : 2'd0;
        w_s_tready = (w_busy & bus.m_axis_tready) ? (4'b0001 << r_grant) : 4'b0000;
        w_xfer     = w_m_tvalid & bus.m_axis_tready;
    end

    assign bus.m_axis_tvalid = w_m_tvalid;
    assign bus.m_axis_tlast  = w_m_tlast;
    assign bus.m_axis_tdata  = w_m_tdata;
    assign bus.m_axis_tid    = w_m_tid;
    assign bus.s_axis_tready = w_s_tready;
    assign bus.trunc_err     = r_trunc_err;

    // Next-state: grant on arbitration, release the grant on the tlast beat
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_beat_cnt_nxt  = r_beat_cnt;
        w_trunc_err_nxt = r_trunc_err;
        case (r_state)
            ST_IDLE: begin
                if (w_win_found) begin
                    w_grant_nxt    = w_win_idx;
                    w_beat_cnt_nxt = '0;
                    w_state_nxt    = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (w_xfer) begin
                    if (w_m_tlast) begin
                        w_state_nxt  = ST_IDLE;
                        w_rr_ptr_nxt = r_grant + 2'd1;
                        // Watchdog cut a packet the source had not finished
                        if (!bus.s_axis_tlast[r_grant]) begin
                            w_trunc_err_nxt = 1'b1;
                        end
                    end else begin
                        w_beat_cnt_nxt = r_beat_cnt + c_CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and arbitration registers, asynchronously cleared
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= ST_IDLE;
            r_grant     <= 2'd0;
            r_rr_ptr    <= 2'd0;
            r_beat_cnt  <= '0;
            r_trunc_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_beat_cnt  <= w_beat_cnt_nxt;
            r_trunc_err <= w_trunc_err_nxt;
        end
    end

endmodule
`default_nettype wire

// File: doc/axis_packet_arbiter.md
# axis_packet_arbiter

Packet-granular round-robin arbiter that shares one AXI4-Stream data FIFO slave port between four AXI4-Stream sources. Sits directly in front of the FIFO. Once a source is granted, the whole packet (through `tlast`) passes before any other source is considered. A beat-count watchdog forces `tlast` on runaway packets so that a source that never terminates its packet cannot starve the others.

## Interface
Parameters:
- `DATA_WIDTH`, 32: stream data width.
- `MAX_BEATS`, 256: maximum beats per forwarded packet, range 2..65535.

Ports:
- `aclk` in 1: single clock; all logic is rising-edge.
- `aresetn` in 1: reset, asynchronous assert, active-low.
- `s_axis_tdata` in 4*DATA_WIDTH: source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `s_axis_tvalid` in 4: per-source valid.
- `s_axis_tlast` in 4: per-source last.
- `s_axis_tready` out 4: per-source ready.
- `m_axis_tdata` out DATA_WIDTH: data to FIFO.
- `m_axis_tvalid` out 1: valid to FIFO.
- `m_axis_tlast` out 1: last to FIFO.
- `m_axis_tid` out 2: index of the granted source.
- `m_axis_tready` in 1: FIFO ready.
- `trunc_err` out 1: sticky; set when the watchdog forces `tlast`.

## Operation
- States: IDLE and BUSY. Registers: `grant[1:0]`, `rr_ptr[1:0]`, `beat_cnt` of width clog2(MAX_BEATS), `trunc_err`.
- IDLE:
  - Winner = first i with `s_axis_tvalid[i]=1`, scanning rr_ptr, rr_ptr+1, … mod 4.
  - If a winner exists: `grant` is set to the winner, `beat_cnt` to 0, and the state moves to BUSY.
  - If no source is valid, stay in IDLE.
  - All `s_axis_tready`=0 and `m_axis_tvalid`=0.
- BUSY (combinational path from the granted source):
  - `m_axis_tvalid = s_axis_tvalid[grant]`.
  - `m_axis_tdata = s_axis_tdata[grant]`.
  - `m_axis_tid = grant`.
  - `s_axis_tready[grant] = m_axis_tready`; all other `s_axis_tready` bits are 0.
- `m_axis_tlast = s_axis_tlast[grant] | (beat_cnt == MAX_BEATS-1)`.
- A beat is transferred when `m_axis_tvalid & m_axis_tready`. On each transferred beat:
  - If `m_axis_tlast`=1: state returns to IDLE and `rr_ptr = grant+1` (mod 4).
  - Otherwise: `beat_cnt` increments.
- Forced last (`beat_cnt==MAX_BEATS-1` and `s_axis_tlast[grant]=0`):
  - `trunc_err` is set to 1 on that beat.
  - The source's remaining beats re-enter arbitration as a new packet.
- `trunc_err` clears only on reset.
- `m_axis_tvalid` deasserting mid-packet (the source stalls) does not release the grant.
- Outputs are never held in a register stage: no extra latency on data, at the cost of combinational paths from the source to the FIFO.

## Timing
- Reset values:
  - state IDLE, `grant`=0, `rr_ptr`=0, `beat_cnt`=0, `trunc_err`=0.
  - `s_axis_tready`=0, `m_axis_tvalid`=0, `m_axis_tlast`=0, `m_axis_tid`=0, `m_axis_tdata`=0.
- Arbitration latency:
  - Source valid at edge N (state IDLE) → BUSY at edge N+1.
  - The first beat can transfer in cycle N+1, when `s_axis_tready` rises.
- Per-packet overhead is exactly 1 idle cycle: after the tlast beat there is always one IDLE cycle before the next grant, even when the same or another source is already valid.
- Throughput inside a packet is 1 beat per cycle while the source is valid and `m_axis_tready`=1.
- Fairness: with all four sources continuously valid, the grant order is 0,1,2,3,0,…
- Asynchronous reset mid-packet:
  - All outputs return to their reset values immediately, without waiting for a clock edge.
  - The partial packet is abandoned; the FIFO sees no `tlast` for it.
- AXIS rules:
  - The block never drops or duplicates a beat.
  - While `m_axis_tvalid`=1 and `m_axis_tready`=0, `m_axis_tdata`, `m_axis_tlast` and `m_axis_tid` stay stable, provided the source obeys AXIS.

## Test plan
- Reset then single source:
  - Stimulus: source 0 sends 16 beats, data 0..15, tlast on 15; `m_axis_tready`=1.
  - Required: `m_axis_tdata` 0..15 on 16 consecutive cycles, `m_axis_tlast` on the beat with data 15, `m_axis_tid`=0.
- Contention:
  - Stimulus: sources 0..3 each hold a 4-beat packet, tdata = 0xA0+i*16+beat, all valid from the same cycle.
  - Required: packets delivered whole in order tid 0,1,2,3, with exactly one idle cycle between packets.
- Round-robin rotation:
  - Stimulus: source 1 sends two back-to-back packets while source 2 is valid.
  - Required: order tid 1, 2, 1.
- Backpressure:
  - Stimulus: toggle `m_axis_tready` 1,0,0,1,… during an 8-beat packet.
  - Required: all 8 beats delivered in order with no loss and no duplicate; output stable while stalled.
- Watchdog (MAX_BEATS=4):
  - Stimulus: source 3 sends 6 beats, tlast on beat 5.
  - Required: the FIFO sees packet {0,1,2,3} with forced tlast on 3, `trunc_err`=1, then packet {4,5} after re-arbitration.
- Reset mid-packet:
  - Stimulus: `aresetn`=0 after beat 2 of 8.
  - Required: `s_axis_tready`, `m_axis_tvalid` and `trunc_err` go 0 immediately. After release, a new packet from source 2 is granted first (rr_ptr=0, source 0 idle).
